// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline register of a 5-stage MIPS pipeline.
// Holds the PC, presents it to instruction memory and latches the fetched word under hazard-unit control.
module if_id_stage #(
  parameter int             PC_W     = 32,
  parameter int             INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int             CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               PCwrite,
  input  logic               if_id_write,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc4,
  output logic               if_id_valid,
  output logic [4:0]         if_id_rs,
  output logic [4:0]         if_id_rt,
  output logic [CNT_W-1:0]   stall_cycles
);

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus4;
  logic            redirect_ok;

  // A redirect arriving while IF/ID is frozen is dropped; ID re-issues it once the stall clears.
  assign redirect_ok = redirect & if_id_write;
  assign pc_plus4    = pc + PC_W'(4);
  assign imem_addr   = pc;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect_ok) begin
      pc <= {redirect_pc[PC_W-1:2], 2'b00};
    end else if (PCwrite) begin
      pc <= pc_plus4;
    end
  end

  // The flush inserts a bubble in place of the wrong-path word fetched this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_instr <= '0;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
    end else if (redirect_ok) begin
      if_id_instr <= '0;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
    end else if (if_id_write) begin
      if_id_instr <= imem_rdata;
      if_id_pc4   <= pc_plus4;
      if_id_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (!PCwrite && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

  assign if_id_rs = if_id_instr[25:21];
  assign if_id_rt = if_id_instr[20:16];

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios plus random hazard/redirect traffic
// compared each cycle against a behavioural pipeline model.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCwrite, if_id_write, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_rdata, if_id_instr, if_id_pc4;
  logic        if_id_valid;
  logic [4:0]  if_id_rs, if_id_rt;
  logic [15:0] stall_cycles;

  // Second instance exercises PC wrap and counter saturation.
  logic        pcw_w, ifw_w;
  logic [31:0] imem_addr_w, imem_rdata_w, if_id_instr_w, if_id_pc4_w;
  logic        if_id_valid_w;
  logic [4:0]  if_id_rs_w, if_id_rt_w;
  logic [1:0]  stall_cycles_w;

  logic [31:0] mem [0:255];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  int          m_stall;

  always #5 clk = ~clk;

  assign imem_rdata   = mem[imem_addr[9:2]];
  assign imem_rdata_w = mem[imem_addr_w[9:2]];

  if_id_stage dut (
    .clk(clk), .rst(rst), .PCwrite(PCwrite), .if_id_write(if_id_write),
    .redirect(redirect), .redirect_pc(redirect_pc), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .stall_cycles(stall_cycles)
  );

  if_id_stage #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) dut_w (
    .clk(clk), .rst(rst), .PCwrite(pcw_w), .if_id_write(ifw_w),
    .redirect(1'b0), .redirect_pc(32'h0), .imem_addr(imem_addr_w),
    .imem_rdata(imem_rdata_w), .if_id_instr(if_id_instr_w), .if_id_pc4(if_id_pc4_w),
    .if_id_valid(if_id_valid_w), .if_id_rs(if_id_rs_w), .if_id_rt(if_id_rt_w),
    .stall_cycles(stall_cycles_w)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".imem_addr"},    imem_addr,           m_pc);
    check({ctx, ".instr"},        if_id_instr,         m_instr);
    check({ctx, ".pc4"},          if_id_pc4,           m_pc4);
    check({ctx, ".valid"},        {31'b0, if_id_valid}, {31'b0, m_valid});
    check({ctx, ".rs"},           {27'b0, if_id_rs},    {27'b0, m_instr[25:21]});
    check({ctx, ".rt"},           {27'b0, if_id_rt},    {27'b0, m_instr[20:16]});
    check({ctx, ".stall_cycles"}, {16'b0, stall_cycles}, 32'(m_stall));
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_stall = 0;
  endtask

  // One clock edge: predict from the architectural rules, then sample 1 time unit after the edge.
  task automatic step(input string ctx);
    logic [31:0] word;
    logic [31:0] n_pc, n_instr, n_pc4;
    logic        n_valid;
    word = mem[m_pc[9:2]];
    n_pc = m_pc; n_instr = m_instr; n_pc4 = m_pc4; n_valid = m_valid;
    if (redirect && if_id_write) begin
      n_pc = redirect_pc & 32'hFFFF_FFFC;
      n_instr = 32'h0; n_pc4 = 32'h0; n_valid = 1'b0;
    end else begin
      if (if_id_write) begin
        n_instr = word; n_pc4 = m_pc + 32'd4; n_valid = 1'b1;
      end
      if (PCwrite) n_pc = m_pc + 32'd4;
    end
    if (!PCwrite && m_stall < 65535) m_stall = m_stall + 1;
    @(posedge clk);
    #1;
    m_pc = n_pc; m_instr = n_instr; m_pc4 = n_pc4; m_valid = n_valid;
    check_all(ctx);
  endtask

  task automatic drive(input logic pcw, input logic ifw, input logic rd, input logic [31:0] rpc);
    PCwrite = pcw; if_id_write = ifw; redirect = rd; redirect_pc = rpc;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h8C22_0004;
    mem[1] = 32'h0043_2020;

    // Reset state without any clock edge
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    pcw_w = 1'b0; ifw_w = 1'b0;
    model_reset();
    #3;
    check_all("reset");
    check("w.reset_addr", imem_addr_w, 32'hFFFF_FFFC);
    @(negedge clk);
    rst = 1'b0;

    // Fetch two words; the wrap instance performs its single fetch edge alongside
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    pcw_w = 1'b1; ifw_w = 1'b1;
    step("fetch1");
    check("fetch1.instr", if_id_instr, 32'h8C22_0004);
    check("w.wrap_addr", imem_addr_w, 32'h0);
    check("w.wrap_pc4", if_id_pc4_w, 32'h0);
    check("w.wrap_valid", {31'b0, if_id_valid_w}, 32'd1);
    pcw_w = 1'b0; ifw_w = 1'b0;
    step("fetch2");
    check("fetch2.instr", if_id_instr, 32'h0043_2020);
    check("fetch2.pc4", if_id_pc4, 32'd8);
    check("fetch2.rs", {27'b0, if_id_rs}, 32'd2);
    check("fetch2.rt", {27'b0, if_id_rt}, 32'd3);

    // Two-cycle stall at pc=8, then resume
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step("stall1");
    step("stall2");
    check("stall.addr", imem_addr, 32'd8);
    check("stall.count", {16'b0, stall_cycles}, 32'd2);
    check("stall.instr", if_id_instr, 32'h0043_2020);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    step("resume");
    check("resume.addr", imem_addr, 32'h0C);
    step("fetch_to_10");
    check("pre_redirect.addr", imem_addr, 32'h10);
    check("w.sat_count", {30'b0, stall_cycles_w}, 32'd3);
    check("w.sat_addr", imem_addr_w, 32'h0);

    // Redirect to an unaligned target: aligned fetch, one bubble
    drive(1'b1, 1'b1, 1'b1, 32'h43);
    step("redirect");
    check("redirect.addr", imem_addr, 32'h40);
    check("redirect.valid", {31'b0, if_id_valid}, 32'd0);
    check("redirect.instr", if_id_instr, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    step("post_redirect");
    check("post_redirect.valid", {31'b0, if_id_valid}, 32'd1);
    check("post_redirect.pc4", if_id_pc4, 32'h44);

    // Redirect while IF/ID is frozen is ignored
    drive(1'b0, 1'b0, 1'b1, 32'h200);
    step("redirect_stalled");
    check("redirect_stalled.addr", imem_addr, 32'h44);
    check("redirect_stalled.valid", {31'b0, if_id_valid}, 32'd1);
    check("redirect_stalled.pc4", if_id_pc4, 32'h44);

    // Random hazard and redirect traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 7) == 0), $urandom);
      step("random");
    end

    // Asynchronous reset mid-operation, observed before any edge
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("midrun_reset");
    check("midrun_reset.addr", imem_addr, 32'h0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step("after_reset");
    check("after_reset.addr", imem_addr, 32'h10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
